// File: rtl/maze_noc_pkg.sv
// maze_noc_pkg: shared flit type, port indices and age width for the mesh link arbiter
`ifndef ID_W
`define ID_W 8
`endif
package maze_noc_pkg;
  localparam int FLIT_TYPE_W = 2;
  localparam int FLIT_DATA_W = 32;
  localparam int AGE_MAX_DEF = 15;
  localparam int AGE_W = $clog2(AGE_MAX_DEF + 1);
  localparam logic [1:0] PORT_LOCAL = 2'd0;
  localparam logic [1:0] PORT_X = 2'd1;
  localparam logic [1:0] PORT_Y = 2'd2;
  typedef struct packed {
    logic qos;
    logic [FLIT_TYPE_W-1:0] typ;
    logic [`ID_W-1:0] src;
    logic [`ID_W-1:0] tgt;
    logic [FLIT_DATA_W-1:0] data;
  } flit_t;
endpackage

// File: rtl/maze_rr_pick.sv
// maze_rr_pick: rotating-priority one-hot picker starting at ptr
module maze_rr_pick #(
  parameter int N = 3,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  mask,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);
  // scan offsets from farthest to nearest so the nearest set bit at or after ptr wins
  always_comb begin
    gnt = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (mask[(int'(ptr) + k) % N]) begin
        gnt = '0;
        gnt[(int'(ptr) + k) % N] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/maze_link_arb.sv
// maze_link_arb: aging/QoS/round-robin output-link arbiter with credit flow control
`ifndef ID_W
`define ID_W 8
`endif
module maze_link_arb
  import maze_noc_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int DATA_W = 32,
  parameter int TYPE_W = 2,
  parameter int CREDITS = 4,
  parameter int AGE_MAX = 15
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          link_en,
  input  logic [NUM_REQ-1:0]            req_vld,
  input  logic [NUM_REQ-1:0]            req_qos,
  input  logic [NUM_REQ*TYPE_W-1:0]     req_type,
  input  logic [NUM_REQ*`ID_W-1:0]      req_src,
  input  logic [NUM_REQ*`ID_W-1:0]      req_tgt,
  input  logic [NUM_REQ*DATA_W-1:0]     req_data,
  output logic [NUM_REQ-1:0]            req_rdy,
  output logic                          out_vld,
  output logic                          out_qos,
  output logic [TYPE_W-1:0]             out_type,
  output logic [`ID_W-1:0]              out_src,
  output logic [`ID_W-1:0]              out_tgt,
  output logic [DATA_W-1:0]             out_data,
  input  logic                          crd_rtn,
  output logic [$clog2(CREDITS+1)-1:0]  crd_cnt,
  output logic [$clog2(NUM_REQ)-1:0]    grant_idx,
  output logic                          crd_err
);
  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = $clog2(CREDITS + 1);
  localparam int AW = $clog2(AGE_MAX + 1);
  logic [NUM_REQ-1:0] elig, urg, mask, pick;
  logic gnt;
  logic [PW-1:0] gidx;
  logic [CW-1:0] crd_q, crd_d;
  logic err_q, err_d;
  logic [PW-1:0] rr_q, rr_d, gidx_q, gidx_d;
  logic [NUM_REQ-1:0][AW-1:0] age_q, age_d;
  logic out_vld_q, out_vld_d, out_qos_q, out_qos_d;
  logic [TYPE_W-1:0] out_type_q, out_type_d;
  logic [`ID_W-1:0] out_src_q, out_src_d, out_tgt_q, out_tgt_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  // eligible requesters split into urgent / high-qos / normal; only the top non-empty class competes
  always_comb begin
    elig = (rst || !link_en || crd_q == '0) ? '0 : req_vld;
    for (int i = 0; i < NUM_REQ; i++) urg[i] = age_q[i] == AW'(AGE_MAX);
    mask = |(elig & urg) ? (elig & urg) : |(elig & req_qos) ? (elig & req_qos) : elig;
  end
  maze_rr_pick #(.N(NUM_REQ), .PW(PW)) u_pick (.mask(mask), .ptr(rr_q), .gnt(pick));
  assign req_rdy = pick;
  // one-hot grant to index
  always_comb begin
    gnt = |pick;
    gidx = '0;
    for (int i = 0; i < NUM_REQ; i++) if (pick[i]) gidx = PW'(i);
  end
  // next state: output capture, pointer, credits and per-requester ages
  always_comb begin
    out_vld_d = gnt;
    out_qos_d = gnt ? req_qos[gidx] : out_qos_q;
    out_type_d = gnt ? req_type[gidx*TYPE_W +: TYPE_W] : out_type_q;
    out_src_d = gnt ? req_src[gidx*`ID_W +: `ID_W] : out_src_q;
    out_tgt_d = gnt ? req_tgt[gidx*`ID_W +: `ID_W] : out_tgt_q;
    out_data_d = gnt ? req_data[gidx*DATA_W +: DATA_W] : out_data_q;
    gidx_d = gnt ? gidx : gidx_q;
    rr_d = !gnt ? rr_q : (gidx == PW'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
    crd_d = !link_en ? CW'(CREDITS)
          : (gnt && !crd_rtn) ? crd_q - 1'b1
          : (!gnt && crd_rtn && crd_q != CW'(CREDITS)) ? crd_q + 1'b1
          : crd_q;
    err_d = err_q | (link_en & crd_rtn & ~gnt & (crd_q == CW'(CREDITS)));
    for (int i = 0; i < NUM_REQ; i++)
      age_d[i] = (!req_vld[i] || pick[i]) ? '0 : (age_q[i] == AW'(AGE_MAX)) ? age_q[i] : age_q[i] + 1'b1;
  end
  // state registers; reset drops any in-flight flit and reloads credits
  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld_q <= 1'b0;
      out_qos_q <= 1'b0;
      out_type_q <= '0;
      out_src_q <= '0;
      out_tgt_q <= '0;
      out_data_q <= '0;
      gidx_q <= '0;
      rr_q <= PW'(PORT_LOCAL);
      crd_q <= CW'(CREDITS);
      err_q <= 1'b0;
      age_q <= '0;
    end else begin
      out_vld_q <= out_vld_d;
      out_qos_q <= out_qos_d;
      out_type_q <= out_type_d;
      out_src_q <= out_src_d;
      out_tgt_q <= out_tgt_d;
      out_data_q <= out_data_d;
      gidx_q <= gidx_d;
      rr_q <= rr_d;
      crd_q <= crd_d;
      err_q <= err_d;
      age_q <= age_d;
    end
  end
  assign out_vld = out_vld_q;
  assign out_qos = out_qos_q;
  assign out_type = out_type_q;
  assign out_src = out_src_q;
  assign out_tgt = out_tgt_q;
  assign out_data = out_data_q;
  assign grant_idx = gidx_q;
  assign crd_cnt = crd_q;
  assign crd_err = err_q;
endmodule

// File: tb/tb_maze_link_arb.sv
// tb_maze_link_arb: directed and randomized traffic against a priority-score reference model
`ifndef ID_W
`define ID_W 8
`endif
module tb_maze_link_arb;
  import maze_noc_pkg::*;
  logic clk = 1'b0, rst, link_en, crd_rtn;
  logic [2:0] req_vld, req_qos, req_rdy;
  logic [5:0] req_type;
  logic [3*`ID_W-1:0] req_src, req_tgt;
  logic [95:0] req_data;
  logic out_vld, out_qos, crd_err;
  logic [1:0] out_type, grant_idx;
  logic [`ID_W-1:0] out_src, out_tgt;
  logic [31:0] out_data;
  logic [2:0] crd_cnt;
  maze_link_arb dut (
    .clk(clk), .rst(rst), .link_en(link_en), .req_vld(req_vld), .req_qos(req_qos),
    .req_type(req_type), .req_src(req_src), .req_tgt(req_tgt), .req_data(req_data),
    .req_rdy(req_rdy), .out_vld(out_vld), .out_qos(out_qos), .out_type(out_type),
    .out_src(out_src), .out_tgt(out_tgt), .out_data(out_data), .crd_rtn(crd_rtn),
    .crd_cnt(crd_cnt), .grant_idx(grant_idx), .crd_err(crd_err)
  );
  always #5 clk = ~clk;
  int checks = 0, errors = 0;
  int spawn_pct, rtn_mode, qos_mode[3];
  logic pend_v[3];
  flit_t pend[3];
  int m_crd, m_rr, m_gidx, m_age[3], win;
  logic m_err, m_ov;
  flit_t m_out;
  int grants_seen;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic cycle();
    int best, cls, sc;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      if (!pend_v[i] && $urandom_range(0, 99) < spawn_pct) begin
        pend_v[i] = 1'b1;
        pend[i].qos = (qos_mode[i] == 2) ? 1'($urandom_range(0, 1)) : 1'(qos_mode[i]);
        pend[i].typ = 2'($urandom);
        pend[i].src = `ID_W'($urandom);
        pend[i].tgt = `ID_W'($urandom);
        pend[i].data = $urandom;
      end
      req_vld[i] = pend_v[i];
      req_qos[i] = pend[i].qos;
      req_type[i*2 +: 2] = pend[i].typ;
      req_src[i*`ID_W +: `ID_W] = pend[i].src;
      req_tgt[i*`ID_W +: `ID_W] = pend[i].tgt;
      req_data[i*32 +: 32] = pend[i].data;
    end
    crd_rtn = (rtn_mode == 1) ? m_ov : (rtn_mode == 3) ? 1'b1
            : (rtn_mode == 2) ? ($urandom_range(0, 99) < (m_crd < 4 ? 50 : 3)) : 1'b0;
    #1;
    win = -1;
    best = 1000;
    if (!rst && link_en && m_crd != 0)
      for (int i = 0; i < 3; i++)
        if (pend_v[i]) begin
          cls = (m_age[i] == 15) ? 0 : pend[i].qos ? 1 : 2;
          sc = cls * 3 + (i - m_rr + 3) % 3;
          if (sc < best) begin best = sc; win = i; end
        end
    chk("req_rdy", 64'(req_rdy), (win < 0) ? 64'd0 : 64'(1) << win);
    @(posedge clk);
    #1;
    if (rst) begin
      m_crd = 4; m_err = 0; m_rr = 0; m_gidx = 0; m_ov = 0; m_out = '0;
      for (int i = 0; i < 3; i++) m_age[i] = 0;
    end else begin
      m_ov = win >= 0;
      if (win >= 0) begin
        m_out = pend[win]; m_gidx = win; m_rr = (win + 1) % 3; grants_seen++;
      end
      if (!link_en) m_crd = 4;
      else if (win >= 0 && !crd_rtn) m_crd--;
      else if (win < 0 && crd_rtn) begin
        if (m_crd == 4) m_err = 1'b1; else m_crd++;
      end
      for (int i = 0; i < 3; i++)
        m_age[i] = (!pend_v[i] || i == win) ? 0 : (m_age[i] < 15 ? m_age[i] + 1 : 15);
      if (win >= 0) pend_v[win] = 1'b0;
    end
    chk("out_vld", 64'(out_vld), 64'(m_ov));
    chk("out_flit", 64'({out_qos, out_type, out_src, out_tgt, out_data}), 64'(m_out));
    chk("crd_cnt", 64'(crd_cnt), 64'(m_crd));
    chk("grant_idx", 64'(grant_idx), 64'(m_gidx));
    chk("crd_err", 64'(crd_err), 64'(m_err));
  endtask
  task automatic run(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask
  task automatic set_qos(input int a, input int b, input int c);
    qos_mode[PORT_LOCAL] = a; qos_mode[PORT_X] = b; qos_mode[PORT_Y] = c;
  endtask
  initial begin
    rst = 1'b1; link_en = 1'b1; crd_rtn = 1'b0; req_vld = '0; req_qos = '0;
    req_type = '0; req_src = '0; req_tgt = '0; req_data = '0;
    spawn_pct = 0; rtn_mode = 0; grants_seen = 0;
    for (int i = 0; i < 3; i++) begin pend_v[i] = 1'b0; pend[i] = '0; m_age[i] = 0; end
    m_crd = 4; m_err = 0; m_rr = 0; m_gidx = 0; m_ov = 0; m_out = '0;
    set_qos(0, 0, 0);
    run(2);
    rst = 1'b0;
    // all requesters valid, low qos, credits returned on each emitted flit
    spawn_pct = 100; rtn_mode = 1;
    run(10);
    // requester 1 high qos starves the others until they age out
    set_qos(0, 1, 0);
    run(25);
    // credit exhaustion, then a single return
    rtn_mode = 0; set_qos(0, 0, 0);
    run(7);
    chk("crd_exhausted", 64'(crd_cnt), 64'd0);
    rtn_mode = 3;
    run(1);
    rtn_mode = 0;
    run(3);
    // neighbour gated: no grants, credits reload, arbitration resumes at held pointer
    link_en = 1'b0;
    run(10);
    chk("gated_crd", 64'(crd_cnt), 64'd4);
    link_en = 1'b1; rtn_mode = 1;
    run(4);
    // credit overflow sets a sticky error that only reset clears
    rst = 1'b1; run(2); rst = 1'b0;
    spawn_pct = 0;
    run(4);
    rtn_mode = 3; run(2); rtn_mode = 0;
    run(3);
    chk("err_sticky", 64'(crd_err), 64'd1);
    spawn_pct = 100; rtn_mode = 1; run(5);
    // reset in the middle of traffic
    rst = 1'b1; run(2); rst = 1'b0;
    chk("rst_err", 64'(crd_err), 64'd0);
    run(4);
    // randomized traffic with random gating, qos and credit returns
    rtn_mode = 2;
    for (int blk = 0; blk < 40; blk++) begin
      spawn_pct = $urandom_range(20, 100);
      set_qos($urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2));
      for (int k = 0; k < 50; k++) begin
        link_en = $urandom_range(0, 9) != 0;
        cycle();
      end
    end
    link_en = 1'b1;
    chk("grants_happened", 64'(grants_seen > 500), 64'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
